// File: rtl/axi_wr_burst_sequencer_if.sv
// rtl/axi_wr_burst_sequencer_if.sv - AXI slave write-channel bundle (AW, W control, B)
//
// Purpose: groups the AW/W/B handshake and control signals seen by the
// write burst sequencer. W data and strobes go to the byte-lane aligner
// directly and are not part of this bundle.
// Ports (modport slave = sequencer side):
//   AW: s_awvalid/s_awready, s_awaddr, s_awlen, s_awsize, s_awburst, s_awid
//   W : s_wvalid/s_wready, s_wlast
//   B : s_bvalid/s_bready, s_bresp, s_bid
interface axi_wr_burst_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8,
  parameter int ID_W   = 4
);
  logic              s_awvalid;
  logic              s_awready;
  logic [ADDR_W-1:0] s_awaddr;
  logic [LEN_W-1:0]  s_awlen;
  logic [2:0]        s_awsize;
  logic [1:0]        s_awburst;
  logic [ID_W-1:0]   s_awid;
  logic              s_wvalid;
  logic              s_wready;
  logic              s_wlast;
  logic              s_bvalid;
  logic              s_bready;
  logic [1:0]        s_bresp;
  logic [ID_W-1:0]   s_bid;

  modport master (
    output s_awvalid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awid,
    output s_wvalid, s_wlast, s_bready,
    input  s_awready, s_wready, s_bvalid, s_bresp, s_bid
  );

  modport slave (
    input  s_awvalid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awid,
    input  s_wvalid, s_wlast, s_bready,
    output s_awready, s_wready, s_bvalid, s_bresp, s_bid
  );
endinterface

// File: rtl/axi_wr_burst_sequencer.sv
// rtl/axi_wr_burst_sequencer.sv - AXI write burst sequencer driving a byte-lane aligner
//
// Purpose: accepts one AW burst at a time, steps through its W beats, steers
// the byte-lane aligner (offset/restart/accumulate), pushes each completed
// 32-bit word to the word sink in the same cycle as its last beat, then
// returns the B response.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   s            AXI AW/W/B bundle (slave modport)
//   aln_addr     aligner byte offset of the current beat
//   aln_strt     aligner restart (first beat of a word)
//   aln_enable   aligner accumulate this beat
//   word_push    aligner output is a complete word this cycle
//   word_addr    word-aligned address of the pushed word
//   word_ready   sink can accept a word
module axi_wr_burst_sequencer #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8,
  parameter int ID_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  axi_wr_burst_sequencer_if.slave  s,
  output logic [1:0]               aln_addr,
  output logic                     aln_strt,
  output logic                     aln_enable,
  output logic                     word_push,
  output logic [ADDR_W-1:0]        word_addr,
  input  logic                     word_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] BURST_FIXED = 2'b00;

  logic [1:0]        state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  len;
  logic [2:0]        sz;
  logic [1:0]        bt;
  logic [ID_W-1:0]   id;
  logic [LEN_W-1:0]  beat_cnt;
  logic              strt_pend;  // next accepted beat starts a fresh word
  logic              err;

  logic              in_data;
  logic              last_beat;
  logic              beat;
  logic              active;
  logic [ADDR_W-1:0] bytes;
  logic [ADDR_W-1:0] next_addr;
  logic              word_cross;

  always_comb begin
    in_data   = (state == DATA);
    last_beat = (beat_cnt == len);
    bytes     = ADDR_W'(1) << sz;
    // INCR aligns down to the size boundary before stepping, so an unaligned
    // first beat only advances to the next boundary.
    if (bt == BURST_FIXED)
      next_addr = cur_addr;
    else
      next_addr = (cur_addr & ~(bytes - ADDR_W'(1))) + bytes;
    word_cross = (next_addr[ADDR_W-1:2] != cur_addr[ADDR_W-1:2]);
    // An errored burst drains W without waiting on the sink.
    beat       = s.s_wvalid & in_data & (word_ready | err);
    active     = beat & ~err;
    aln_enable = active;
    aln_strt   = active & strt_pend;
    word_push  = active & ((bt == BURST_FIXED) | last_beat | word_cross);
    aln_addr   = in_data ? cur_addr[1:0] : 2'b00;
    word_addr  = in_data ? {cur_addr[ADDR_W-1:2], 2'b00} : '0;
  end

  assign s.s_awready = (state == IDLE);
  assign s.s_wready  = in_data & (word_ready | err);
  assign s.s_bvalid  = (state == RESP);
  assign s.s_bresp   = ((state == RESP) && err) ? 2'b10 : 2'b00;
  assign s.s_bid     = (state == RESP) ? id : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      len       <= '0;
      sz        <= '0;
      bt        <= '0;
      id        <= '0;
      beat_cnt  <= '0;
      strt_pend <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s.s_awvalid) begin
            cur_addr  <= s.s_awaddr;
            len       <= s.s_awlen;
            sz        <= s.s_awsize;
            bt        <= s.s_awburst;
            id        <= s.s_awid;
            beat_cnt  <= '0;
            strt_pend <= 1'b1;
            // Sizes above 32 bits and WRAP/reserved bursts are not supported.
            err       <= (s.s_awsize > 3'd2) | s.s_awburst[1];
            state     <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            cur_addr  <= next_addr;
            beat_cnt  <= beat_cnt + LEN_W'(1);
            strt_pend <= word_push;
            if (last_beat) begin
              state <= RESP;
              if (!s.s_wlast) err <= 1'b1;
            end else if (s.s_wlast) begin
              err <= 1'b1;
            end
          end
        end
        RESP: begin
          if (s.s_bready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_burst_sequencer.sv
// tb/tb_axi_wr_burst_sequencer.sv - directed table-driven bench for axi_wr_burst_sequencer
module tb_axi_wr_burst_sequencer;

  localparam int ADDR_W = 32;
  localparam int LEN_W  = 8;
  localparam int ID_W   = 4;

  localparam logic [1:0] OP_AW = 2'd0;
  localparam logic [1:0] OP_W  = 2'd1;
  localparam logic [1:0] OP_B  = 2'd2;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
    logic        wlast;
    logic        wr;
    logic        e_wready;
    logic [1:0]  e_aln;
    logic        e_strt;
    logic        e_en;
    logic        e_push;
    logic [31:0] e_waddr;
    logic [1:0]  e_bresp;
    logic [3:0]  e_bid;
  } vec_t;

  logic              clk;
  logic              rst;
  logic [1:0]        aln_addr;
  logic              aln_strt;
  logic              aln_enable;
  logic              word_push;
  logic [ADDR_W-1:0] word_addr;
  logic              word_ready;

  int tests;
  int fails;

  axi_wr_burst_sequencer_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .ID_W(ID_W)) bus ();

  axi_wr_burst_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .s          (bus.slave),
    .aln_addr   (aln_addr),
    .aln_strt   (aln_strt),
    .aln_enable (aln_enable),
    .word_push  (word_push),
    .word_addr  (word_addr),
    .word_ready (word_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk_aw(input logic [31:0] a, input logic [7:0] l,
                                 input logic [2:0] sz, input logic [1:0] b, input logic [3:0] i);
    vec_t v = '{default: '0};
    v.op = OP_AW; v.addr = a; v.len = l; v.size = sz; v.burst = b; v.id = i;
    return v;
  endfunction

  function automatic vec_t mk_w(input logic wl, input logic wr, input logic ewr,
                                input logic [1:0] eal, input logic est, input logic een,
                                input logic epu, input logic [31:0] ewa);
    vec_t v = '{default: '0};
    v.op = OP_W; v.wlast = wl; v.wr = wr; v.e_wready = ewr; v.e_aln = eal;
    v.e_strt = est; v.e_en = een; v.e_push = epu; v.e_waddr = ewa;
    return v;
  endfunction

  function automatic vec_t mk_b(input logic [1:0] r, input logic [3:0] i);
    vec_t v = '{default: '0};
    v.op = OP_B; v.e_bresp = r; v.e_bid = i;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.s_awvalid = 1'b0; bus.s_awaddr = '0; bus.s_awlen = '0; bus.s_awsize = '0;
    bus.s_awburst = '0; bus.s_awid = '0; bus.s_wvalid = 1'b0; bus.s_wlast = 1'b0;
    bus.s_bready = 1'b0; word_ready = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " awready"}, 32'(bus.s_awready), 32'd1);
    chk({tag, " wready"},  32'(bus.s_wready),  32'd0);
    chk({tag, " bvalid"},  32'(bus.s_bvalid),  32'd0);
    chk({tag, " bresp"},   32'(bus.s_bresp),   32'd0);
    chk({tag, " bid"},     32'(bus.s_bid),     32'd0);
    chk({tag, " aln_addr"}, 32'(aln_addr),     32'd0);
    chk({tag, " strt/en/push"}, {29'd0, aln_strt, aln_enable, word_push}, 32'd0);
    chk({tag, " word_addr"}, word_addr, 32'd0);
  endtask

  // Called aligned to posedge+1; returns aligned to the next posedge+1.
  task automatic apply_vec(input vec_t v, input int n);
    string t;
    t = $sformatf("v%0d", n);
    case (v.op)
      OP_AW: begin
        bus.s_awvalid = 1'b1; bus.s_awaddr = v.addr; bus.s_awlen = v.len;
        bus.s_awsize = v.size; bus.s_awburst = v.burst; bus.s_awid = v.id;
        @(negedge clk);
        chk({t, " awready"}, 32'(bus.s_awready), 32'd1);
        @(posedge clk); #1;
        bus.s_awvalid = 1'b0;
      end
      OP_W: begin
        bus.s_wvalid = 1'b1; bus.s_wlast = v.wlast; word_ready = v.wr;
        @(negedge clk);
        chk({t, " wready"},     32'(bus.s_wready), 32'(v.e_wready));
        chk({t, " aln_enable"}, 32'(aln_enable),   32'(v.e_en));
        chk({t, " aln_strt"},   32'(aln_strt),     32'(v.e_strt));
        chk({t, " word_push"},  32'(word_push),    32'(v.e_push));
        chk({t, " awready"},    32'(bus.s_awready), 32'd0);
        chk({t, " bvalid"},     32'(bus.s_bvalid), 32'd0);
        if (v.e_en)   chk({t, " aln_addr"},  32'(aln_addr), 32'(v.e_aln));
        if (v.e_push) chk({t, " word_addr"}, word_addr,     v.e_waddr);
        @(posedge clk); #1;
        bus.s_wvalid = 1'b0; bus.s_wlast = 1'b0; word_ready = 1'b1;
      end
      default: begin
        bus.s_bready = 1'b1;
        @(negedge clk);
        chk({t, " bvalid"},  32'(bus.s_bvalid),  32'd1);
        chk({t, " bresp"},   32'(bus.s_bresp),   32'(v.e_bresp));
        chk({t, " bid"},     32'(bus.s_bid),     32'(v.e_bid));
        chk({t, " awready"}, 32'(bus.s_awready), 32'd0);
        @(posedge clk); #1;
        bus.s_bready = 1'b0;
      end
    endcase
  endtask

  vec_t tbl[$];
  vec_t post[$];

  initial begin
    tests = 0;
    fails = 0;

    // 1: INCR byte beats, two full words
    tbl.push_back(mk_aw(32'h100, 8'd7, 3'd0, 2'b01, 4'h5));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk_w(i == 7, 1'b1, 1'b1, 2'(i % 4), (i == 0) || (i == 4), 1'b1,
                         (i == 3) || (i == 7), (i < 4) ? 32'h100 : 32'h104));
    tbl.push_back(mk_b(2'b00, 4'h5));
    // 2: INCR word beats from an unaligned start
    tbl.push_back(mk_aw(32'h203, 8'd1, 3'd2, 2'b01, 4'hA));
    tbl.push_back(mk_w(1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 32'h200));
    tbl.push_back(mk_w(1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 32'h204));
    tbl.push_back(mk_b(2'b00, 4'hA));
    // 3: halfword beats with a two-cycle sink stall before beat1
    tbl.push_back(mk_aw(32'h10, 8'd2, 3'd1, 2'b01, 4'h3));
    tbl.push_back(mk_w(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0));
    tbl.push_back(mk_w(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk_w(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk_w(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 32'h10));
    tbl.push_back(mk_w(1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 32'h14));
    tbl.push_back(mk_b(2'b00, 4'h3));
    // 4: FIXED byte beats, every beat is its own word
    tbl.push_back(mk_aw(32'h31, 8'd3, 3'd0, 2'b00, 4'h7));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk_w(i == 3, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 32'h30));
    tbl.push_back(mk_b(2'b00, 4'h7));
    // 5a: WRAP is rejected; beats drain even with the sink stalled
    tbl.push_back(mk_aw(32'h80, 8'd3, 3'd2, 2'b10, 4'h1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk_w(i == 3, i != 1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk_b(2'b10, 4'h1));
    // 5b: awsize=3 is rejected
    tbl.push_back(mk_aw(32'h80, 8'd1, 3'd3, 2'b01, 4'h2));
    tbl.push_back(mk_w(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk_w(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk_b(2'b10, 4'h2));
    // 5c: early wlast on beat1 of len=3; pushes stop after beat1
    tbl.push_back(mk_aw(32'h40, 8'd3, 3'd2, 2'b01, 4'h4));
    tbl.push_back(mk_w(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 32'h40));
    tbl.push_back(mk_w(1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 32'h44));
    tbl.push_back(mk_w(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk_w(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk_b(2'b10, 4'h4));
    // 5d: missing wlast on the final beat still pushes, then SLVERR
    tbl.push_back(mk_aw(32'h8, 8'd0, 3'd2, 2'b01, 4'h6));
    tbl.push_back(mk_w(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 32'h8));
    tbl.push_back(mk_b(2'b10, 4'h6));
    // 5e: clean single-beat INCR after the errored bursts
    tbl.push_back(mk_aw(32'h0, 8'd0, 3'd2, 2'b01, 4'h9));
    tbl.push_back(mk_w(1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 32'h0));
    tbl.push_back(mk_b(2'b00, 4'h9));

    // Burst that follows the mid-burst reset
    post.push_back(mk_aw(32'h300, 8'd1, 3'd1, 2'b01, 4'hB));
    post.push_back(mk_w(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0));
    post.push_back(mk_w(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 32'h300));
    post.push_back(mk_b(2'b00, 4'hB));

    idle_inputs();
    rst = 1'b1;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++)
      apply_vec(tbl[i], i);

    // 6: reset during beat2 of a len=7 burst
    apply_vec(mk_aw(32'h200, 8'd7, 3'd0, 2'b01, 4'hC), 100);
    apply_vec(mk_w(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0), 101);
    apply_vec(mk_w(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 32'h0), 102);
    bus.s_wvalid = 1'b1;
    bus.s_bready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("rst_async");
    @(posedge clk); #1;
    check_all_zero("rst_held");
    rst = 1'b0;
    bus.s_wvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d bvalid", c), 32'(bus.s_bvalid), 32'd0);
      chk($sformatf("post_rst%0d awready", c), 32'(bus.s_awready), 32'd1);
      @(posedge clk); #1;
    end
    bus.s_bready = 1'b0;
    for (int i = 0; i < post.size(); i++)
      apply_vec(post[i], 200 + i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_wr_burst_sequencer.md
Name: axi_wr_burst_sequencer

Overview:
- Controller for the AXI slave write path. It accepts one AW burst at a time and steps through its W beats.
- For each beat it drives the byte-lane aligner's offset, restart and accumulate controls.
- When a 32-bit word is complete it pushes the aligner output to the word sink (memory or FIFO), then returns the B response.
- Bursts never overlap: a new AW is accepted only after the previous B handshake.

Parameters:
ADDR_W  32  byte address width
LEN_W   8   AXI awlen width
ID_W    4   AXI ID width

Ports:
clk          in   1       clock
rst          in   1       asynchronous reset, active-high
s_awvalid    in   1       AW valid
s_awready    out  1       AW ready
s_awaddr     in   ADDR_W  burst start byte address
s_awlen      in   LEN_W   beats minus 1
s_awsize     in   3       log2 bytes per beat
s_awburst    in   2       00 FIXED, 01 INCR, 10 WRAP, 11 reserved
s_awid       in   ID_W    transaction ID
s_wvalid     in   1       W valid
s_wready     out  1       W ready
s_wlast      in   1       W last
s_bvalid     out  1       B valid
s_bready     in   1       B ready
s_bresp      out  2       00 OKAY, 10 SLVERR
s_bid        out  ID_W    echoed ID
aln_addr     out  2       aligner byte offset (cur_addr[1:0])
aln_strt     out  1       aligner restart
aln_enable   out  1       aligner accumulate
word_push    out  1       aligner formatted_data is a complete word this cycle
word_addr    out  ADDR_W  word-aligned address of pushed word
word_ready   in   1       sink can accept a word

Behaviour:
- Reset (async, rst=1): state=IDLE; s_wready, s_bvalid, aln_strt, aln_enable, word_push = 0; s_bresp, s_bid, aln_addr, word_addr = 0; s_awready = 1 (decoded as state==IDLE).
- Reset mid-burst abandons the burst. No B response is issued for it.
- State machine: IDLE, DATA, RESP.
- IDLE:
  - s_awready=1.
  - On s_awvalid, latch addr/len/size/burst/id into cur_addr, len, sz, bt, id.
  - Clear beat_cnt and the first flag. Set err if s_awsize>2 or s_awburst[1]==1.
  - Go to DATA.
- DATA:
  - s_wready = word_ready | err.
  - beat = s_wvalid & s_wready.
  - aln_addr = cur_addr[1:0], combinational.
  - aln_enable = beat & ~err.
  - aln_strt = beat & ~err & (first beat of burst, or previous beat pushed).
- Increment, with B = 1<<sz:
  - INCR: next_addr = (cur_addr & ~(B-1)) + B. The first unaligned beat covers bytes up to the next size boundary.
  - FIXED: next_addr = cur_addr.
  - 4 KB crossing is not checked; the master guarantees it.
- Push:
  - word_push = beat & ~err & (bt==FIXED | beat_cnt==len | next_addr[ADDR_W-1:2] != cur_addr[ADDR_W-1:2]).
  - word_addr = {cur_addr[ADDR_W-1:2], 2'b00}.
  - Same cycle as the beat (zero latency); the aligner output is combinational.
- On every beat: cur_addr <= next_addr, beat_cnt++.
- Burst termination: the burst ends on the beat where beat_cnt==len, then go to RESP.
  - s_wlast==1 on an earlier beat sets err; the remaining beats are consumed with no push.
  - s_wlast==0 on the final beat also sets err.
- word_ready low: s_wready low, no beat is taken, and all aligner controls are 0. Stalls of any length are legal.
- RESP:
  - s_bvalid=1, s_bresp = err ? 2'b10 : 2'b00, s_bid=id.
  - Hold until s_bready, then go to IDLE.
  - s_awready stays 0 during DATA and RESP.
- Errored burst: every W beat is accepted, and word_push, aln_enable, aln_strt stay 0 throughout.
- Arithmetic: beat_cnt is LEN_W bits, compared against len (max 256 beats); it has no wrap issue. Address arithmetic is modulo 2^ADDR_W.

Test Plan:
1. INCR, size=0, len=7, addr=0x100, word_ready=1 -> aln_addr 0,1,2,3,0,1,2,3; aln_strt on beats 0 and 4; pushes on beats 3 and 7 with word_addr 0x100 and 0x104; bresp=00, bid echoed.
2. INCR, size=2, addr=0x203, len=1 -> beat0: aln_addr=3, push 0x200; beat1: aln_addr=0, push 0x204; aln_strt on both beats; bresp=00.
3. INCR, size=1, addr=0x10, len=2; word_ready=0 for 2 cycles before beat1 -> s_wready=0 and no pushes while stalled; pushes at beat1 (0x10) and beat2 (0x14, final partial word).
4. FIXED, size=0, addr=0x31, len=3 -> 4 pushes, all word_addr 0x30; aln_addr=1 and aln_strt=1 on every beat.
5. WRAP burst, or awsize=3, or s_wlast at beat1 of len=3 -> all beats accepted; WRAP/awsize=3: no pushes, zero aligner controls; early s_wlast: pushes stop after beat1; bresp=10. Then a clean INCR burst -> bresp=00.
6. rst asserted during beat2 of a len=7 burst -> next cycle all outputs 0 and s_awready=1, no B response; a following burst completes with bresp=00.
